// File: rtl/nnet_framer_pkg.sv
// Shared constants for the neural-net stream framer: counter width, default SPP
// and the CHDR-style tuser field layout used to build output packet headers.
package nnet_framer_pkg;

    localparam int              CNT_W         = 16;
    localparam logic [CNT_W-1:0] DEFAULT_SPP  = 16'd64;

    localparam int              TUSER_W       = 128;
    localparam logic [1:0]      PKT_TYPE_DATA = 2'b00;
    localparam int              PKT_TYPE_LSB  = 126;
    localparam int              HAS_TIME_BIT  = 125;
    localparam int              EOB_BIT       = 124;
    localparam int              SEQNUM_LSB    = 112;
    localparam int              SEQNUM_W      = 12;
    localparam int              LENGTH_LSB    = 96;
    localparam int              LENGTH_W      = 16;
    localparam int              SID_W         = 16;
    localparam int              SRC_SID_LSB   = 80;
    localparam int              DST_SID_LSB   = 64;

    function automatic logic [TUSER_W-1:0] make_tuser(input logic [SID_W-1:0] src,
                                                      input logic [SID_W-1:0] dst);
        logic [TUSER_W-1:0] u;
        u = '0;
        u[PKT_TYPE_LSB +: 2]        = PKT_TYPE_DATA;
        u[HAS_TIME_BIT]             = 1'b0;
        u[EOB_BIT]                  = 1'b0;
        u[SEQNUM_LSB +: SEQNUM_W]   = '0;
        // Length is left at zero; axi_wrapper fills it in once the packet is sized.
        u[LENGTH_LSB +: LENGTH_W]   = '0;
        u[SRC_SID_LSB +: SID_W]     = src;
        u[DST_SID_LSB +: SID_W]     = dst;
        return u;
    endfunction

endpackage

// File: rtl/nnet_skid_buf.sv
// Two-entry AXI-stream skid buffer with a registered output stage; a clear
// drops both entries and blocks acceptance for that cycle.
module nnet_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic [W-1:0] s_data_i,
    input  logic         s_valid_i,
    output logic         s_ready_o,
    output logic [W-1:0] m_data_o,
    output logic         m_valid_o,
    input  logic         m_ready_i
);

    logic         out_vld_q, out_vld_d, skd_vld_q, skd_vld_d;
    logic [W-1:0] out_dat_q, out_dat_d, skd_dat_q, skd_dat_d;
    logic         in_fire;

    assign s_ready_o = !skd_vld_q && !clear;
    assign in_fire   = s_valid_i && s_ready_o;
    assign m_data_o  = out_dat_q;
    assign m_valid_o = out_vld_q;

    always_comb begin
        out_vld_d = out_vld_q;
        out_dat_d = out_dat_q;
        skd_vld_d = skd_vld_q;
        skd_dat_d = skd_dat_q;
        if (!out_vld_q || m_ready_i) begin
            if (skd_vld_q) begin
                out_vld_d = 1'b1;
                out_dat_d = skd_dat_q;
                skd_vld_d = 1'b0;
            end else begin
                out_vld_d = in_fire;
                if (in_fire) out_dat_d = s_data_i;
            end
        end else if (in_fire) begin
            // Output stalled: park the beat so the upstream ready stays registered.
            skd_vld_d = 1'b1;
            skd_dat_d = s_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            out_vld_q <= 1'b0;
            skd_vld_q <= 1'b0;
        end else begin
            out_vld_q <= out_vld_d;
            skd_vld_q <= skd_vld_d;
        end
        if (reset) out_dat_q <= '0;
        else       out_dat_q <= out_dat_d;
        skd_dat_q <= skd_dat_d;
    end

endmodule

// File: rtl/nnet_stream_framer.sv
// Frames axi_wrapper samples into core vectors and re-packetises core output into
// SPP-sized packets. Statistics counters are built only with NNET_FRAMER_STATS_EN.
module nnet_stream_framer
    import nnet_framer_pkg::*;
#(
    parameter logic [7:0] SR_USER_SPP = 8'd131,
    parameter int         DATA_W      = 32,
    parameter int         CORE_IN_W   = 18,
    parameter int         CORE_OUT_W  = 18
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         set_stb,
    input  logic [7:0]                   set_addr,
    input  logic [31:0]                  set_data,
    input  logic [15:0]                  src_sid,
    input  logic [15:0]                  next_dst_sid,
    input  logic [CNT_W-1:0]             nnet_size_in,
    input  logic [CNT_W-1:0]             nnet_size_out,
    output logic [CNT_W-1:0]             spp_out,
    input  logic [DATA_W-1:0]            i_tdata,
    input  logic                         i_tlast,
    input  logic                         i_tvalid,
    output logic                         i_tready,
    input  logic [127:0]                 i_tuser,
    output logic [DATA_W-1:0]            o_tdata,
    output logic                         o_tlast,
    output logic                         o_tvalid,
    input  logic                         o_tready,
    output logic [127:0]                 o_tuser,
    output logic [CORE_IN_W-1:0]         m_core_tdata,
    output logic                         m_core_tlast,
    output logic                         m_core_tvalid,
    input  logic                         m_core_tready,
    input  logic signed [CORE_OUT_W-1:0] s_core_tdata,
    input  logic                         s_core_tvalid,
    output logic                         s_core_tready,
    output logic [31:0]                  stat_in_vec,
    output logic [31:0]                  stat_out_pkt,
    output logic [31:0]                  stat_misalign
);

    localparam int SKID_W = TUSER_W + 1 + DATA_W;

    function automatic logic [DATA_W-1:0] sext_core(input logic signed [CORE_OUT_W-1:0] x);
        return DATA_W'(x);
    endfunction

    logic [CNT_W-1:0]  vin, vout, spp_now, spp_cur;
    logic [CNT_W-1:0]  in_cnt_q, in_cnt_d, pkt_cnt_q, pkt_cnt_d, vec_cnt_q, vec_cnt_d;
    logic [CNT_W-1:0]  spp_q, spp_eff_q, spp_eff_d;
    logic [31:0]       hdr_q, hdr_d, hdr_cur;
    logic              in_beat, in_end, core_beat, first, pkt_end, vec_end, out_last;
    logic [SKID_W-1:0] skid_in, skid_out;

    assign vin  = (nnet_size_in  == '0) ? CNT_W'(1) : nnet_size_in;
    assign vout = (nnet_size_out == '0) ? CNT_W'(1) : nnet_size_out;

    assign m_core_tdata  = i_tdata[CORE_IN_W-1:0];
    assign m_core_tvalid = i_tvalid;
    assign i_tready      = m_core_tready;
    assign in_beat       = i_tvalid && m_core_tready;
    assign in_end        = (in_cnt_q >= vin - CNT_W'(1));
    assign m_core_tlast  = in_end;

    assign spp_out   = spp_q;
    assign first     = (pkt_cnt_q == '0);
    // Packet settings are taken live on the first beat and frozen for the rest.
    assign spp_now   = (spp_q == '0) ? vout : spp_q;
    assign spp_cur   = first ? spp_now : spp_eff_q;
    assign hdr_cur   = first ? {src_sid, next_dst_sid} : hdr_q;
    assign pkt_end   = (pkt_cnt_q >= spp_cur - CNT_W'(1));
    assign vec_end   = (vec_cnt_q >= vout - CNT_W'(1));
    assign out_last  = pkt_end || vec_end;
    assign core_beat = s_core_tvalid && s_core_tready;
    assign skid_in   = {make_tuser(hdr_cur[31:16], hdr_cur[15:0]), out_last, sext_core(s_core_tdata)};

    always_comb begin
        in_cnt_d  = in_cnt_q;
        pkt_cnt_d = pkt_cnt_q;
        vec_cnt_d = vec_cnt_q;
        spp_eff_d = spp_eff_q;
        hdr_d     = hdr_q;
        if (in_beat) in_cnt_d = in_end ? '0 : in_cnt_q + CNT_W'(1);
        if (core_beat) begin
            pkt_cnt_d = out_last ? '0 : pkt_cnt_q + CNT_W'(1);
            vec_cnt_d = vec_end  ? '0 : vec_cnt_q + CNT_W'(1);
            if (first) begin
                spp_eff_d = spp_now;
                hdr_d     = {src_sid, next_dst_sid};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            in_cnt_q  <= '0;
            pkt_cnt_q <= '0;
            vec_cnt_q <= '0;
        end else begin
            in_cnt_q  <= in_cnt_d;
            pkt_cnt_q <= pkt_cnt_d;
            vec_cnt_q <= vec_cnt_d;
        end
        spp_eff_q <= spp_eff_d;
        hdr_q     <= hdr_d;
        if (reset)                                 spp_q <= DEFAULT_SPP;
        else if (set_stb && set_addr == SR_USER_SPP) spp_q <= set_data[CNT_W-1:0];
    end

    nnet_skid_buf #(.W(SKID_W)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .s_data_i  (skid_in),
        .s_valid_i (s_core_tvalid),
        .s_ready_o (s_core_tready),
        .m_data_o  (skid_out),
        .m_valid_o (o_tvalid),
        .m_ready_i (o_tready)
    );

    assign {o_tuser, o_tlast, o_tdata} = skid_out;

`ifdef NNET_FRAMER_STATS_EN
    logic [31:0] st_in_q, st_out_q, st_mis_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            st_in_q  <= '0;
            st_out_q <= '0;
            st_mis_q <= '0;
        end else begin
            if (in_beat && in_end)                st_in_q  <= st_in_q + 32'd1;
            if (o_tvalid && o_tready && o_tlast)  st_out_q <= st_out_q + 32'd1;
            if (in_beat && i_tlast && !in_end)    st_mis_q <= st_mis_q + 32'd1;
        end
    end

    assign stat_in_vec   = st_in_q;
    assign stat_out_pkt  = st_out_q;
    assign stat_misalign = st_mis_q;

    logic unused_bits;
    assign unused_bits = ^{i_tuser, i_tdata[DATA_W-1:CORE_IN_W], set_data[31:CNT_W]};
`else
    assign stat_in_vec   = '0;
    assign stat_out_pkt  = '0;
    assign stat_misalign = '0;

    logic unused_bits;
    assign unused_bits = ^{i_tuser, i_tlast, i_tdata[DATA_W-1:CORE_IN_W], set_data[31:CNT_W]};
`endif

endmodule

// File: tb/tb_nnet_stream_framer.sv
// Randomised scoreboard bench for nnet_stream_framer: the output stream is checked
// against a packet/vector splitting model, the input path against beat counting.
module tb_nnet_stream_framer;

    logic         clk = 1'b0;
    logic         reset, clear, set_stb;
    logic [7:0]   set_addr;
    logic [31:0]  set_data;
    logic [15:0]  src_sid, next_dst_sid, nnet_size_in, nnet_size_out, spp_out;
    logic [31:0]  i_tdata, o_tdata;
    logic         i_tlast, i_tvalid, i_tready, o_tlast, o_tvalid, o_tready;
    logic [127:0] i_tuser, o_tuser;
    logic [17:0]  m_core_tdata;
    logic         m_core_tlast, m_core_tvalid, m_core_tready;
    logic [17:0]  s_core_tdata;
    logic         s_core_tvalid, s_core_tready;
    logic [31:0]  stat_in_vec, stat_out_pkt, stat_misalign;

    nnet_stream_framer dut (
        .clk(clk), .reset(reset), .clear(clear),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .src_sid(src_sid), .next_dst_sid(next_dst_sid),
        .nnet_size_in(nnet_size_in), .nnet_size_out(nnet_size_out), .spp_out(spp_out),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready), .i_tuser(i_tuser),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready), .o_tuser(o_tuser),
        .m_core_tdata(m_core_tdata), .m_core_tlast(m_core_tlast), .m_core_tvalid(m_core_tvalid),
        .m_core_tready(m_core_tready),
        .s_core_tdata(s_core_tdata), .s_core_tvalid(s_core_tvalid), .s_core_tready(s_core_tready),
        .stat_in_vec(stat_in_vec), .stat_out_pkt(stat_out_pkt), .stat_misalign(stat_misalign)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] user;
        logic         last;
        logic [31:0]  data;
    } beat_t;

    beat_t       exp_q[$];
    int          nvec = 0, nerr = 0;
    int          rem_pkt = 0, rem_vec = 0, mspp = 64;
    logic [31:0] cur_hdr = '0;
    int          in_acc = 0, in_vecs_m = 0, mis_m = 0, out_pkts_m = 0;
    int          rdy_mode = 0, pat_i = 0;
    logic        held_v = 1'b0;
    beat_t       held;

    task automatic check(input string name, input logic [160:0] act, input logic [160:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference: each vector of vout beats is cut into packets of min(spp, beats left).
    function automatic void push_exp(input logic [17:0] d);
        beat_t b;
        int    v, vo, se;
        vo = (nnet_size_out == 16'd0) ? 1 : int'(nnet_size_out);
        if (rem_pkt == 0) begin
            if (rem_vec == 0) rem_vec = vo;
            se      = (mspp == 0) ? vo : mspp;
            rem_pkt = (se < rem_vec) ? se : rem_vec;
            cur_hdr = {src_sid, next_dst_sid};
        end
        v = int'(d);
        if (d[17]) v = v - 262144;
        b.data = 32'(v);
        b.last = (rem_pkt == 1);
        b.user = '0;
        b.user[95:64] = cur_hdr;
        rem_pkt--;
        rem_vec--;
        exp_q.push_back(b);
    endfunction

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       o_tready = 1'b1;
            1:       o_tready = 1'($urandom_range(1));
            2:       begin o_tready = (pat_i % 4 == 0) || (pat_i % 4 == 3); pat_i++; end
            default: o_tready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (held_v && o_tvalid)
                check("hold_stable", 161'({o_tuser, o_tlast, o_tdata}), 161'(held));
            held_v = 1'b0;
            if (o_tvalid && o_tready) begin
                if (exp_q.size() == 0) begin
                    nvec++; nerr++;
                    $display("FAIL out_extra: got %h want no beat", {o_tuser, o_tlast, o_tdata});
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("out_beat", 161'({o_tuser, o_tlast, o_tdata}), 161'(e));
                    if (e.last) out_pkts_m++;
                end
            end else if (o_tvalid) begin
                held_v = 1'b1;
                held   = {o_tuser, o_tlast, o_tdata};
            end
        end
    end

    task automatic check_stats();
`ifdef NNET_FRAMER_STATS_EN
        check("stat_in_vec",   161'(stat_in_vec),   161'(in_vecs_m));
        check("stat_out_pkt",  161'(stat_out_pkt),  161'(out_pkts_m));
        check("stat_misalign", 161'(stat_misalign), 161'(mis_m));
`else
        check("stat_in_vec",   161'(stat_in_vec),   161'(0));
        check("stat_out_pkt",  161'(stat_out_pkt),  161'(0));
        check("stat_misalign", 161'(stat_misalign), 161'(0));
`endif
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        exp_q.delete();
        rem_pkt = 0; rem_vec = 0; in_acc = 0;
        in_vecs_m = 0; mis_m = 0; out_pkts_m = 0;
    endtask

    task automatic set_spp(input logic [7:0] addr, input logic [15:0] v);
        set_stb = 1'b1; set_addr = addr; set_data = {16'h0, v};
        @(posedge clk); #1;
        set_stb = 1'b0;
        if (addr == 8'd131) mspp = int'(v);
    endtask

    task automatic in_beats(input int n, input int tlast_at, input bit rnd);
        int  acc = 0, guard = 0;
        bit  exp_last;
        int  vi;
        vi = (nnet_size_in == 16'd0) ? 1 : int'(nnet_size_in);
        while (acc < n && guard < 2000) begin
            i_tvalid      = rnd ? ($urandom_range(3) != 0) : 1'b1;
            i_tdata       = $urandom;
            i_tlast       = (acc + 1 == tlast_at);
            m_core_tready = rnd ? ($urandom_range(3) != 0) : 1'b1;
            @(negedge clk);
            check("core_tdata",  161'(m_core_tdata),  161'(i_tdata[17:0]));
            check("core_tvalid", 161'(m_core_tvalid), 161'(i_tvalid));
            check("i_tready",    161'(i_tready),      161'(m_core_tready));
            if (i_tvalid && m_core_tready) begin
                exp_last = ((in_acc % vi) == vi - 1);
                check("core_tlast", 161'(m_core_tlast), 161'(exp_last));
                if (exp_last) in_vecs_m++;
                if (i_tlast && !exp_last) mis_m++;
                in_acc++;
                acc++;
            end
            @(posedge clk); #1;
            guard++;
        end
        i_tvalid = 1'b0; i_tlast = 1'b0;
        if (acc < n) begin
            nvec++; nerr++;
            $display("FAIL in_timeout: got %0d beats want %0d", acc, n);
        end
    endtask

    task automatic core_beats(input int n, input int bubble_pct, input int wr_at,
                              input logic [15:0] wr_val, input int fixed, input bit rnd_sid);
        int sent = 0, guard = 0;
        bit wrote = 0, accepted;
        s_core_tvalid = 1'b0;
        while (sent < n && guard < 2000) begin
            if (!s_core_tvalid) begin
                s_core_tvalid = ($urandom_range(99) >= bubble_pct);
                s_core_tdata  = (fixed >= 0) ? 18'(fixed) : 18'($urandom);
                if (rnd_sid) src_sid = 16'($urandom);
            end
            set_stb  = (!wrote && sent == wr_at);
            set_addr = 8'd131;
            set_data = {16'h0, wr_val};
            @(negedge clk);
            accepted = s_core_tvalid && s_core_tready;
            if (accepted) begin
                push_exp(s_core_tdata);
                sent++;
            end
            if (set_stb) begin
                mspp  = int'(wr_val);
                wrote = 1;
            end
            @(posedge clk); #1;
            set_stb = 1'b0;
            if (accepted) s_core_tvalid = 1'b0;
            guard++;
        end
        s_core_tvalid = 1'b0;
        if (sent < n) begin
            nvec++; nerr++;
            $display("FAIL core_timeout: got %0d beats want %0d", sent, n);
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 500) begin
            @(posedge clk);
            guard++;
        end
        @(posedge clk); #1;
        check("drain_left", 161'(exp_q.size()), 161'(0));
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
        src_sid = 16'h1234; next_dst_sid = 16'h5678;
        nnet_size_in = 16'd4; nnet_size_out = 16'd10;
        i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0; i_tuser = '0;
        o_tready = 1'b1; m_core_tready = 1'b1; s_core_tdata = '0; s_core_tvalid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_o_tvalid", 161'(o_tvalid), 161'(0));
        check("rst_o_tlast",  161'(o_tlast),  161'(0));
        check("rst_o_tdata",  161'(o_tdata),  161'(0));
        check("rst_o_tuser",  161'(o_tuser),  161'(0));
        check("rst_spp_out",  161'(spp_out),  161'(64));
        check_stats();
        @(posedge clk); #1;
        reset = 1'b0;

        // Input framing: whole vectors, then a short input packet that ends early.
        in_beats(12, 0, 0);
        check_stats();
        in_beats(6, 6, 0);
        in_beats(2, 0, 0);
        check_stats();
        do_clear();
        nnet_size_in = 16'd0;
        in_beats(10, 3, 1);
        check_stats();
        do_clear();
        nnet_size_in = 16'd5;
        in_beats(40, 7, 1);
        check_stats();

        // Output framing: vout=10, spp=4, then an spp change inside a packet.
        do_clear();
        nnet_size_out = 16'd10;
        set_spp(8'd131, 16'd4);
        check("spp_write", 161'(spp_out), 161'(4));
        set_spp(8'd130, 16'd99);
        check("spp_other_addr", 161'(spp_out), 161'(4));
        core_beats(20, 0, -1, 16'd0, -1, 0);
        drain();
        check_stats();
        core_beats(20, 0, 2, 16'd8, -1, 0);
        drain();
        check("spp_after_mid", 161'(spp_out), 161'(8));

        // Ready pattern 1,0,0,1 with spp=0 and header changing beat to beat.
        nnet_size_out = 16'd7;
        set_spp(8'd131, 16'd0);
        rdy_mode = 2;
        core_beats(30, 0, -1, 16'd0, -1, 1);
        rdy_mode = 0;
        drain();
        check_stats();

        // Stall with both entries full, sign extension, then clear mid-packet.
        do_clear();
        nnet_size_out = 16'd10;
        set_spp(8'd131, 16'd4);
        rdy_mode = 3;
        repeat (2) @(posedge clk); #1;
        core_beats(2, 0, -1, 16'd0, 18'h20000, 0);
        @(negedge clk);
        check("full_tready", 161'(s_core_tready), 161'(0));
        check("sext_tdata",  161'(o_tdata),       161'(32'hFFFE0000));
        check("stall_valid", 161'(o_tvalid),      161'(1));
        @(posedge clk); #1;
        do_clear();
        @(negedge clk);
        check("clear_valid", 161'(o_tvalid), 161'(0));
        check("clear_spp",   161'(spp_out),  161'(4));
        rdy_mode = 0;
        @(posedge clk); #1;
        core_beats(20, 0, -1, 16'd0, -1, 0);
        drain();
        check_stats();

        // Randomised backpressure, bubbles and an spp change mid-stream.
        nnet_size_out = 16'd5;
        set_spp(8'd131, 16'd3);
        rdy_mode = 1;
        core_beats(60, 30, 20, 16'd0, -1, 1);
        core_beats(15, 30, 3, 16'd2, -1, 0);
        rdy_mode = 0;
        drain();
        check_stats();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
